// File: rtl/spi_tft_window_flush.sv
// Streams one rectangular pixel window to an SPI TFT panel: CASET/RASET/RAMWR header,
// then raster-order pixel bytes from the pixel source, with abort and window-error reporting.
module spi_tft_window_flush #(
    parameter int         COORD_W   = 16,
    parameter int         BPP       = 2,
    parameter int         DC_DELAY  = 5,
    parameter logic [7:0] CMD_CASET = 8'h2A,
    parameter logic [7:0] CMD_RASET = 8'h2B,
    parameter logic [7:0] CMD_RAMWR = 8'h2C,
    parameter int         PIX_W     = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               flush_req_i,
    input  logic [COORD_W-1:0] win_x0_i,
    input  logic [COORD_W-1:0] win_y0_i,
    input  logic [COORD_W-1:0] win_x1_i,
    input  logic [COORD_W-1:0] win_y1_i,
    input  logic               abort_i,
    input  logic [8*BPP-1:0]   pix_data_i,
    output logic               pix_rd_o,
    output logic [COORD_W-1:0] pix_x_o,
    output logic [COORD_W-1:0] pix_y_o,
    output logic               busy_o,
    output logic               fsync_o,
    output logic               err_o,
    output logic               spi_req_o,
    output logic               spi_end_o,
    input  logic               spi_ack_i,
    output logic [7:0]         spi_data_o,
    output logic               spi_dc_o,
    output logic [2:0]         state_o
);

    // SPI handshake: spi_req_o is held high with spi_data_o/spi_dc_o stable until the
    // master returns a one-cycle spi_ack_i; the byte is transferred in that ack cycle.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DLY  = 3'd2,
        S_PIX  = 3'd3,
        S_SYNC = 3'd4,
        S_ABRT = 3'd5
    } state_t;

    localparam int DLY_W = $clog2(DC_DELAY + 2);

    state_t             state, state_nxt;
    logic [3:0]         hdr_idx;
    logic [DLY_W-1:0]   dly_cnt;
    logic [1:0]         byte_idx;
    logic [COORD_W-1:0] win_x0_q, win_y0_q, win_x1_q, win_y1_q;
    logic [PIX_W-1:0]   pix_left;

    logic               win_ok, start, hdr_ack, pix_ack, last_byte, pix_done, last_pix, dly_done;
    logic [COORD_W:0]   win_w, win_h;
    logic [15:0]        x0_16, x1_16, y0_16, y1_16;
    logic [7:0]         hdr_byte, pix_byte;
    logic               hdr_dc;

    assign win_ok    = (win_x1_i >= win_x0_i) && (win_y1_i >= win_y0_i);
    assign start     = (state == S_IDLE) && flush_req_i && win_ok;
    assign hdr_ack   = (state == S_HDR) && spi_ack_i && !abort_i;
    assign pix_ack   = (state == S_PIX) && spi_ack_i && !abort_i;
    assign last_byte = (byte_idx == 2'(BPP - 1));
    assign pix_done  = pix_ack && last_byte;
    assign last_pix  = (pix_left == PIX_W'(1));
    assign dly_done  = (dly_cnt == DLY_W'(DC_DELAY));
    assign win_w     = {1'b0, win_x1_i} - {1'b0, win_x0_i} + (COORD_W+1)'(1);
    assign win_h     = {1'b0, win_y1_i} - {1'b0, win_y0_i} + (COORD_W+1)'(1);
    assign state_o   = state;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_HDR;
            S_HDR: begin
                if (abort_i)        state_nxt = S_ABRT;
                else if (spi_ack_i) state_nxt = S_DLY;
            end
            S_DLY: begin
                if (abort_i)       state_nxt = S_ABRT;
                else if (dly_done) state_nxt = (hdr_idx == 4'd11) ? S_PIX : S_HDR;
            end
            S_PIX: begin
                if (abort_i)                   state_nxt = S_ABRT;
                else if (pix_done && last_pix) state_nxt = S_SYNC;
            end
            S_SYNC:  state_nxt = S_IDLE;
            S_ABRT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_o    <= 1'b0;
            hdr_idx  <= '0;
            dly_cnt  <= '0;
            byte_idx <= '0;
            win_x0_q <= '0;
            win_y0_q <= '0;
            win_x1_q <= '0;
            win_y1_q <= '0;
            pix_x_o  <= '0;
            pix_y_o  <= '0;
            pix_left <= '0;
        end else begin
            err_o <= (state == S_IDLE) && flush_req_i && !win_ok;
            if (start) begin
                win_x0_q <= win_x0_i;
                win_y0_q <= win_y0_i;
                win_x1_q <= win_x1_i;
                win_y1_q <= win_y1_i;
                pix_x_o  <= win_x0_i;
                pix_y_o  <= win_y0_i;
                hdr_idx  <= '0;
                byte_idx <= '0;
                pix_left <= PIX_W'(win_w) * PIX_W'(win_h);
            end
            if (hdr_ack) hdr_idx <= hdr_idx + 4'd1;
            if (state == S_DLY && !dly_done) dly_cnt <= dly_cnt + DLY_W'(1);
            else                             dly_cnt <= '0;
            // Raster walk: the column wraps to x0 after x1 and the row advances.
            if (pix_ack) begin
                if (last_byte) begin
                    byte_idx <= '0;
                    pix_left <= pix_left - PIX_W'(1);
                    if (pix_x_o == win_x1_q) begin
                        pix_x_o <= win_x0_q;
                        pix_y_o <= pix_y_o + COORD_W'(1);
                    end else begin
                        pix_x_o <= pix_x_o + COORD_W'(1);
                    end
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

    assign x0_16 = 16'(win_x0_q);
    assign x1_16 = 16'(win_x1_q);
    assign y0_16 = 16'(win_y0_q);
    assign y1_16 = 16'(win_y1_q);

    always_comb begin
        hdr_byte = 8'h00;
        unique case (hdr_idx)
            4'd0:    hdr_byte = CMD_CASET;
            4'd1:    hdr_byte = x0_16[15:8];
            4'd2:    hdr_byte = x0_16[7:0];
            4'd3:    hdr_byte = x1_16[15:8];
            4'd4:    hdr_byte = x1_16[7:0];
            4'd5:    hdr_byte = CMD_RASET;
            4'd6:    hdr_byte = y0_16[15:8];
            4'd7:    hdr_byte = y0_16[7:0];
            4'd8:    hdr_byte = y1_16[15:8];
            4'd9:    hdr_byte = y1_16[7:0];
            4'd10:   hdr_byte = CMD_RAMWR;
            default: hdr_byte = 8'h00;
        endcase
    end

    assign hdr_dc   = !((hdr_idx == 4'd0) || (hdr_idx == 4'd5) || (hdr_idx == 4'd10));
    // Pixel bytes leave MSB first: byte 0 is the top byte of pix_data_i.
    assign pix_byte = 8'(pix_data_i >> (8 * (BPP - 1 - int'(byte_idx))));

    always_comb begin
        spi_req_o  = 1'b0;
        spi_end_o  = 1'b0;
        spi_data_o = 8'h00;
        spi_dc_o   = 1'b0;
        pix_rd_o   = 1'b0;
        fsync_o    = 1'b0;
        busy_o     = (state != S_IDLE);
        unique case (state)
            S_HDR: begin
                spi_req_o  = 1'b1;
                spi_data_o = hdr_byte;
                spi_dc_o   = hdr_dc;
            end
            S_DLY: spi_end_o = 1'b1;
            S_PIX: begin
                spi_req_o  = 1'b1;
                spi_dc_o   = 1'b1;
                spi_data_o = pix_byte;
                pix_rd_o   = pix_done;
            end
            S_SYNC: begin
                fsync_o   = 1'b1;
                spi_end_o = 1'b1;
            end
            S_ABRT:  spi_end_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_tft_window_flush.sv
// Bench for spi_tft_window_flush: table and random windows against a raster-order byte
// model, plus hand sequences for abort, mid-frame reset and a BPP=3 instance.
module tb_spi_tft_window_flush;

    localparam int DC_DELAY = 5;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        flush_a = 0, flush_b = 0, abort = 0, spi_ack = 0, sel = 0;
    logic [15:0] wx0 = 0, wy0 = 0, wx1 = 0, wy1 = 0;
    logic [23:0] pix_in = 0;
    logic        ack_a, ack_b;
    assign ack_a = spi_ack & ~sel;
    assign ack_b = spi_ack & sel;

    logic        a_pix_rd, a_busy, a_fsync, a_err, a_req, a_end, a_dc;
    logic [15:0] a_x, a_y;
    logic [7:0]  a_data;
    logic [2:0]  a_state;
    logic        b_pix_rd, b_busy, b_fsync, b_err, b_req, b_end, b_dc;
    logic [15:0] b_x, b_y;
    logic [7:0]  b_data;
    logic [2:0]  b_state;

    spi_tft_window_flush #(.BPP(2), .DC_DELAY(DC_DELAY)) u_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush_req_i(flush_a),
        .win_x0_i(wx0), .win_y0_i(wy0), .win_x1_i(wx1), .win_y1_i(wy1),
        .abort_i(abort), .pix_data_i(pix_in[15:0]), .pix_rd_o(a_pix_rd),
        .pix_x_o(a_x), .pix_y_o(a_y), .busy_o(a_busy), .fsync_o(a_fsync), .err_o(a_err),
        .spi_req_o(a_req), .spi_end_o(a_end), .spi_ack_i(ack_a), .spi_data_o(a_data),
        .spi_dc_o(a_dc), .state_o(a_state));

    spi_tft_window_flush #(.BPP(3), .DC_DELAY(DC_DELAY)) u_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush_req_i(flush_b),
        .win_x0_i(wx0), .win_y0_i(wy0), .win_x1_i(wx1), .win_y1_i(wy1),
        .abort_i(abort), .pix_data_i(pix_in), .pix_rd_o(b_pix_rd),
        .pix_x_o(b_x), .pix_y_o(b_y), .busy_o(b_busy), .fsync_o(b_fsync), .err_o(b_err),
        .spi_req_o(b_req), .spi_end_o(b_end), .spi_ack_i(ack_b), .spi_data_o(b_data),
        .spi_dc_o(b_dc), .state_o(b_state));

    logic        m_pix_rd, m_busy, m_fsync, m_err, m_req, m_end, m_dc;
    logic [15:0] m_x, m_y;
    logic [7:0]  m_data;
    assign m_pix_rd = sel ? b_pix_rd : a_pix_rd;
    assign m_busy   = sel ? b_busy   : a_busy;
    assign m_fsync  = sel ? b_fsync  : a_fsync;
    assign m_err    = sel ? b_err    : a_err;
    assign m_req    = sel ? b_req    : a_req;
    assign m_end    = sel ? b_end    : a_end;
    assign m_dc     = sel ? b_dc     : a_dc;
    assign m_x      = sel ? b_x      : a_x;
    assign m_y      = sel ? b_y      : a_y;
    assign m_data   = sel ? b_data   : a_data;

    // scoreboard state
    logic [8:0]  exp_q[$];
    logic [8:0]  got_q[$];
    logic [31:0] exp_xy[$];
    logic [31:0] got_xy[$];
    int          end_runs[$];
    logic [23:0] pix_mem [256];
    int          pix_idx, fsync_cnt, err_cnt, overlap_cnt, end_run, ack_wait;
    logic        busy_seen, req_seen, last_req, last_err;
    logic        auto_ack = 0, pend_a = 0, pend_b = 0, pend_abort = 0, pend_force = 0;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [15:0] x0, y0, x1, y1;
        logic        exp_err;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample once combinational outputs settle.
    task automatic step();
        @(negedge sys_clk);
        flush_a = pend_a;     pend_a = 0;
        flush_b = pend_b;     pend_b = 0;
        abort   = pend_abort; pend_abort = 0;
        pix_in  = pix_mem[pix_idx & 255];
        spi_ack = 0;
        if (pend_force) spi_ack = 1;
        else if (auto_ack && m_req) begin
            if (ack_wait == 0) begin
                spi_ack = 1;
                ack_wait = $urandom_range(0, 3);
            end else ack_wait--;
        end
        pend_force = 0;
        #1;
        if (m_req && spi_ack && !abort) got_q.push_back({m_dc, m_data});
        if (m_pix_rd) begin
            got_xy.push_back({m_x, m_y});
            pix_idx++;
        end
        if (m_fsync) fsync_cnt++;
        if (m_err) err_cnt++;
        if (m_busy) busy_seen = 1;
        if (m_req) req_seen = 1;
        if (m_end && m_req) overlap_cnt++;
        if (m_end) end_run++;
        else if (end_run > 0) begin
            end_runs.push_back(end_run);
            end_run = 0;
        end
        last_req = m_req;
        last_err = m_err;
    endtask

    // Reference: header bytes from the corners, then raster-order pixels, MSB byte first.
    task automatic build_model(input int x0, input int y0, input int x1, input int y1, input int bpp);
        logic [15:0] c;
        int k;
        exp_q.delete();
        exp_xy.delete();
        exp_q.push_back({1'b0, 8'h2A});
        c = 16'(x0); exp_q.push_back({1'b1, c[15:8]}); exp_q.push_back({1'b1, c[7:0]});
        c = 16'(x1); exp_q.push_back({1'b1, c[15:8]}); exp_q.push_back({1'b1, c[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        c = 16'(y0); exp_q.push_back({1'b1, c[15:8]}); exp_q.push_back({1'b1, c[7:0]});
        c = 16'(y1); exp_q.push_back({1'b1, c[15:8]}); exp_q.push_back({1'b1, c[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
        k = 0;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                for (int b = 0; b < bpp; b++) exp_q.push_back({1'b1, pix_mem[k][8*(bpp-1-b) +: 8]});
                exp_xy.push_back({16'(x), 16'(y)});
                k++;
            end
        end
    endtask

    task automatic clear_mon();
        got_q.delete(); got_xy.delete(); end_runs.delete();
        pix_idx = 0; fsync_cnt = 0; err_cnt = 0; overlap_cnt = 0; end_run = 0;
        busy_seen = 0; req_seen = 0; ack_wait = $urandom_range(0, 3);
    endtask

    task automatic start_frame(input logic s, input logic [15:0] x0, input logic [15:0] y0,
                               input logic [15:0] x1, input logic [15:0] y1);
        sel = s;
        wx0 = x0; wy0 = y0; wx1 = x1; wy1 = y1;
        clear_mon();
        auto_ack = 1;
        if (s) pend_b = 1; else pend_a = 1;
        step();
        step();
    endtask

    task automatic run_frame(input string tag, input logic s, input logic [15:0] x0,
                             input logic [15:0] y0, input logic [15:0] x1, input logic [15:0] y1,
                             input logic exp_err, input logic [23:0] fixed_pix);
        int n;
        for (int i = 0; i < 256; i++) pix_mem[i] = 24'($urandom);
        if (fixed_pix != 0) pix_mem[0] = fixed_pix;
        start_frame(s, x0, y0, x1, y1);
        if (exp_err) begin
            check({tag, "_err_n1"}, 32'(last_err), 1);
            repeat (6) step();
            check({tag, "_err_cnt"}, err_cnt, 1);
            check({tag, "_no_req"}, 32'(req_seen), 0);
            check({tag, "_no_busy"}, 32'(busy_seen), 0);
            return;
        end
        check({tag, "_req_n1"}, 32'(last_req), 1);
        n = 0;
        while (fsync_cnt == 0 && n < 5000) begin
            step();
            n++;
        end
        check({tag, "_fsync_seen"}, 32'(fsync_cnt != 0), 1);
        repeat (3) step();
        build_model(int'(x0), int'(y0), int'(x1), int'(y1), s ? 3 : 2);
        check({tag, "_byte_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_pix_rd_count"}, got_xy.size(), exp_xy.size());
        for (int i = 0; i < exp_xy.size() && i < got_xy.size(); i++)
            check($sformatf("%s_xy%0d", tag, i), got_xy[i], exp_xy[i]);
        check({tag, "_fsync_cnt"}, fsync_cnt, 1);
        check({tag, "_end_runs"}, end_runs.size(), 12);
        for (int i = 0; i < 11 && i < end_runs.size(); i++)
            check($sformatf("%s_dly_len%0d", tag, i), end_runs[i], DC_DELAY + 1);
        check({tag, "_req_end_overlap"}, overlap_cnt, 0);
        check({tag, "_idle_after"}, 32'(m_busy), 0);
    endtask

    // Abort lands on the ack of byte number n_before+1 of the frame.
    task automatic abort_test(input string tag, input int n_before);
        int n;
        for (int i = 0; i < 256; i++) pix_mem[i] = 24'($urandom);
        start_frame(0, 16'd0, 16'd0, 16'd3, 16'd0);
        n = 0;
        while (got_q.size() < n_before && n < 2000) begin
            step();
            n++;
        end
        check({tag, "_reached"}, got_q.size(), n_before);
        auto_ack = 0;
        step();
        check({tag, "_req_pending"}, 32'(m_req), 1);
        pend_abort = 1;
        pend_force = 1;
        step();
        check({tag, "_no_pix_rd"}, 32'(m_pix_rd), 0);
        step();
        check({tag, "_abrt_end"}, 32'(m_end), 1);
        check({tag, "_abrt_req"}, 32'(m_req), 0);
        check({tag, "_abrt_busy"}, 32'(m_busy), 1);
        step();
        check({tag, "_idle"}, 32'(m_busy), 0);
        check({tag, "_end_low"}, 32'(m_end), 0);
        check({tag, "_no_fsync"}, fsync_cnt, 0);
        check({tag, "_pix_consumed"}, got_xy.size(), 1);
    endtask

    logic [7:0] hdr_ref [11];
    logic [15:0] rx0, ry0;

    initial begin
        vecs[0] = '{16'd10, 16'd20, 16'd12, 16'd21, 1'b0};
        vecs[1] = '{16'd5, 16'd0, 16'd4, 16'd0, 1'b1};
        vecs[2] = '{16'd0, 16'd0, 16'd0, 16'd0, 1'b0};
        vecs[3] = '{16'd300, 16'd7, 16'd302, 16'd9, 1'b0};
        vecs[4] = '{16'd0, 16'd5, 16'd0, 16'd4, 1'b1};
        vecs[5] = '{16'd65534, 16'd65535, 16'd65535, 16'd65535, 1'b0};
        vecs[6] = '{16'd256, 16'd511, 16'd259, 16'd511, 1'b0};
        vecs[7] = '{16'd7, 16'd3, 16'd7, 16'd3, 1'b0};
        for (int i = 0; i < 256; i++) pix_mem[i] = 24'($urandom);
        clear_mon();

        // reset state
        repeat (3) @(negedge sys_clk);
        #1;
        check("rst_req", 32'(a_req), 0);
        check("rst_end", 32'(a_end), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_data", 32'(a_data), 0);
        check("rst_xy", {a_x, a_y}, 0);
        check("rst_err_fsync_rd", {29'd0, a_err, a_fsync, a_pix_rd}, 0);
        @(negedge sys_clk);
        sys_rst_n = 1;
        repeat (2) step();

        for (int v = 0; v < 8; v++)
            run_frame($sformatf("vec%0d", v), 0, vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1,
                      vecs[v].exp_err, 24'd0);

        // literal header for (10,20)-(12,21)
        hdr_ref = '{8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0C, 8'h2B, 8'h00, 8'h14, 8'h00, 8'h15, 8'h2C};
        run_frame("small", 0, 16'd10, 16'd20, 16'd12, 16'd21, 1'b0, 24'd0);
        for (int i = 0; i < 11 && i < got_q.size(); i++)
            check($sformatf("small_hdr_lit%0d", i), 32'(got_q[i][7:0]), 32'(hdr_ref[i]));

        // full-screen header, then abort partway into the pixels
        start_frame(0, 16'd0, 16'd0, 16'd319, 16'd239);
        for (int n = 0; n < 2000 && got_q.size() < 16; n++) step();
        pend_abort = 1;
        repeat (4) step();
        hdr_ref = '{8'h2A, 8'h00, 8'h00, 8'h01, 8'h3F, 8'h2B, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h2C};
        check("full_hdr_count", 32'(got_q.size() >= 16), 1);
        for (int i = 0; i < 11 && i < got_q.size(); i++)
            check($sformatf("full_hdr%0d", i), 32'(got_q[i][7:0]), 32'(hdr_ref[i]));
        for (int i = 11; i < 16 && i < got_q.size(); i++)
            check($sformatf("full_pix_dc%0d", i), 32'(got_q[i][8]), 1);
        check("full_no_fsync", fsync_cnt, 0);
        check("full_idle", 32'(m_busy), 0);

        // abort coincident with a pixel-byte ack, then a clean restart
        abort_test("abort3", 13);
        run_frame("after_abort3", 0, 16'd1, 16'd1, 16'd2, 16'd1, 1'b0, 24'd0);
        abort_test("abort4", 14);
        run_frame("after_abort4", 0, 16'd4, 16'd2, 16'd4, 16'd3, 1'b0, 24'd0);

        // BPP=3 single pixel
        run_frame("bpp3", 1, 16'd9, 16'd9, 16'd9, 16'd9, 1'b0, 24'hA1B2C3);
        hdr_ref = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 3 && 11 + i < got_q.size(); i++)
            check($sformatf("bpp3_lit%0d", i), 32'(got_q[11+i][7:0]), 32'(hdr_ref[i]));
        sel = 0;

        // reset asserted mid-PIX
        start_frame(0, 16'd2, 16'd2, 16'd5, 16'd5);
        for (int n = 0; n < 2000 && got_q.size() < 14; n++) step();
        #1 sys_rst_n = 0;
        #1;
        check("mrst_req", 32'(a_req), 0);
        check("mrst_end", 32'(a_end), 0);
        check("mrst_busy", 32'(a_busy), 0);
        check("mrst_data_dc", {23'd0, a_dc, a_data}, 0);
        check("mrst_xy", {a_x, a_y}, 0);
        check("mrst_pulses", {29'd0, a_err, a_fsync, a_pix_rd}, 0);
        auto_ack = 0;
        spi_ack = 0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1;
        run_frame("after_rst", 0, 16'd2, 16'd2, 16'd3, 16'd2, 1'b0, 24'd0);

        // randomized windows, including rejected ones
        for (int r = 0; r < 10; r++) begin
            rx0 = 16'($urandom_range(0, 1000));
            ry0 = 16'($urandom_range(0, 600));
            if ($urandom_range(0, 4) == 0)
                run_frame($sformatf("rnd%0d", r), 0, rx0 + 16'd1, ry0, rx0, ry0, 1'b1, 24'd0);
            else
                run_frame($sformatf("rnd%0d", r), r[0], rx0, ry0,
                          rx0 + 16'($urandom_range(0, 5)), ry0 + 16'($urandom_range(0, 3)),
                          1'b0, 24'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
